// File: rtl/seq_det_pkg.sv
// Shared constants for the sequence-detector event logger.
// Holds the default timestamp width, detection-counter width and event
// queue depth, plus a pointer-width helper used by the queue.
// No ports; imported by the logger, its queue and its bus interface.
package seq_det_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // Pointer width for a queue of the given depth (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/det_event_logger_if.sv
// Event bus between the detection logger and its consumer.
// Signals:
//   ev_valid  queue non-empty, head event presented
//   ev_ready  consumer accepts the head event
//   ev_time   timestamp of the head event (0 when ev_valid=0)
//   ev_count  total detections since reset or clear (saturating)
//   overflow  sticky: an event was dropped because the queue was full
// Modports: master (logger side), slave (consumer side).
interface det_event_logger_if
  import seq_det_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             ev_valid;
  logic             ev_ready;
  logic [TS_W-1:0]  ev_time;
  logic [CNT_W-1:0] ev_count;
  logic             overflow;

  modport master (
    output ev_valid,
    output ev_time,
    output ev_count,
    output overflow,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_time,
    input  ev_count,
    input  overflow,
    output ev_ready
  );

endinterface

// File: rtl/event_fifo.sv
// Timestamp event queue for the detection logger.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear        synchronous soft clear (empties the queue)
//   push, din    write din when not full, or when full with a pop at the same edge
//   pop          remove the head entry; ignored while empty
//   dout         head entry, forced to 0 while empty
//   full, empty  occupancy flags
// Pointers wrap naturally since DEPTH is a power of two.
module event_fifo
  import seq_det_pkg::*;
#(
  parameter int DATA_W = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int            AW       = ptr_w(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // A pop on an empty queue is ignored, so a simultaneous push simply
  // becomes the new head. A pop frees the slot a push into a full queue needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; it needs no reset because the pointers
  // and count decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/det_event_logger.sv
// Detection event logger: timestamps detection strobes from an upstream
// sequence detector and queues them for a consumer.
// Ports:
//   clk     single clock, rising edge
//   reset   synchronous active-high reset (highest priority)
//   det_in  detection strobe from the detector output
//   clr     synchronous soft clear of queue, counter and overflow flag;
//           the timestamp keeps running and a same-edge detection is lost
//   ev_bus  event bus (master): ev_valid/ev_ready/ev_time/ev_count/overflow
// Configuration macro DET_EDGE_EN: when defined only rising edges of det_in
// count as detections; otherwise every cycle with det_in=1 counts.
module det_event_logger
  import seq_det_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                det_in,
  input  logic                clr,
  det_event_logger_if.master  ev_bus
);

  logic [TS_W-1:0]  ts_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             ovf_p0;
  logic             det_q;
  logic             push;
  logic             pop;
  logic             drop;
  logic [TS_W-1:0]  head;
  logic             fifo_full;
  logic             fifo_empty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef DET_EDGE_EN
  logic det_p1;

  always_ff @(posedge clk) begin
    if (reset) det_p1 <= 1'b0;
    else       det_p1 <= det_in;
  end

  assign det_q = det_in && !det_p1;
`else
  assign det_q = det_in;
`endif

  assign pop  = !fifo_empty && ev_bus.ev_ready;
  assign push = det_q && !clr;
  // A detection is lost only when the queue is full and nothing leaves it.
  assign drop = push && fifo_full && !pop;

  // Free-running timestamp; clr does not stop or reset it.
  always_ff @(posedge clk) begin
    if (reset) ts_p0 <= '0;
    else       ts_p0 <= ts_p0 + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_p0 <= '0;
      ovf_p0 <= 1'b0;
    end else begin
      if (det_q) cnt_p0 <= sat_inc(cnt_p0);
      if (drop)  ovf_p0 <= 1'b1;
    end
  end

  event_fifo #(
    .DATA_W (TS_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clr),
    .push  (push),
    .pop   (pop),
    .din   (ts_p0),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_bus.ev_valid = !fifo_empty;
  assign ev_bus.ev_time  = head;
  assign ev_bus.ev_count = cnt_p0;
  assign ev_bus.overflow = ovf_p0;

endmodule

// File: tb/tb_det_event_logger.sv
module tb_det_event_logger;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic det_in = 1'b0;
  logic clr = 1'b0;

  det_event_logger_if bus ();

  det_event_logger dut (
    .clk    (clk),
    .reset  (reset),
    .det_in (det_in),
    .clr    (clr),
    .ev_bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rst;
    logic        clr;
    logic        det;
    logic        rdy;
    logic        v;
    logic [15:0] t;
    logic [7:0]  c;
    logic        o;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic cl, input logic d, input logic y,
                     input logic v, input logic [15:0] t, input logic [7:0] c,
                     input logic o);
    vec_t e;
    e.rst = r; e.clr = cl; e.det = d; e.rdy = y;
    e.v = v; e.t = t; e.c = c; e.o = o;
    vq.push_back(e);
  endtask

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic r, input logic cl, input logic d, input logic y);
    reset = r; clr = cl; det_in = d; bus.ev_ready = y;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input string field,
                     input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s %s: got %0d expected %0d", nm, field, act, exp);
    end
  endtask

  task automatic check(input string nm, input logic v, input logic [15:0] t,
                       input logic [7:0] c, input logic o);
    cmp(nm, "ev_valid", 16'(bus.ev_valid), 16'(v));
    cmp(nm, "ev_time",  bus.ev_time,       t);
    cmp(nm, "ev_count", 16'(bus.ev_count), 16'(c));
    cmp(nm, "overflow", 16'(bus.overflow), 16'(o));
  endtask

  initial begin
    bus.ev_ready = 1'b0;

    // rst clr det rdy | valid time count ovf
    add(1,0,0,0, 0, 0,0,0);   // reset held two cycles
    add(1,0,0,0, 0, 0,0,0);
    add(0,0,0,0, 0, 0,0,0);   // ts 0
    add(0,0,0,0, 0, 0,0,0);   // ts 1
    add(0,0,0,0, 0, 0,0,0);   // ts 2
    add(0,0,0,0, 0, 0,0,0);   // ts 3
    add(0,0,0,0, 0, 0,0,0);   // ts 4
    add(0,0,1,0, 1, 5,1,0);   // detection at ts 5
    add(0,0,0,0, 1, 5,1,0);   // held while not ready
    add(0,0,0,1, 0, 0,1,0);   // popped
    add(1,0,0,0, 0, 0,0,0);   // reset again
    add(0,0,0,0, 0, 0,0,0);   // ts 0
    add(0,0,0,0, 0, 0,0,0);   // ts 1
    add(0,0,0,0, 0, 0,0,0);   // ts 2
    add(0,0,1,0, 1, 3,1,0);   // ts 3
    add(0,0,0,0, 1, 3,1,0);
    add(0,0,0,0, 1, 3,1,0);
    add(0,0,1,0, 1, 3,2,0);   // ts 6
    add(0,0,0,0, 1, 3,2,0);
    add(0,0,0,0, 1, 3,2,0);
    add(0,0,1,0, 1, 3,3,0);   // ts 9
    add(0,0,0,0, 1, 3,3,0);
    add(0,0,0,0, 1, 3,3,0);
    add(0,0,1,0, 1, 3,4,0);   // ts 12, queue full
    add(0,0,0,0, 1, 3,4,0);
    add(0,0,0,0, 1, 3,4,0);
    add(0,0,1,0, 1, 3,5,1);   // ts 15 dropped
    add(0,0,0,1, 1, 6,5,1);   // drain
    add(0,0,0,1, 1, 9,5,1);
    add(0,0,0,1, 1,12,5,1);
    add(0,0,0,1, 0, 0,5,1);
    add(0,0,0,1, 0, 0,5,1);   // ready while empty
    add(0,1,0,0, 0, 0,0,0);   // clr drops overflow and count

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].clr, vq[i].det, vq[i].rdy);
      check($sformatf("row%0d", i), vq[i].v, vq[i].t, vq[i].c, vq[i].o);
    end

    // Full queue with simultaneous push and pop.
    step(1,0,0,0); check("full_rst", 0, 0, 0, 0);
    step(0,0,1,0); check("full_e0", 1, 0, 1, 0);
    step(0,0,0,0);
    step(0,0,1,0);
    step(0,0,0,0);
    step(0,0,1,0);
    step(0,0,0,0);
    step(0,0,1,0); check("full_e6", 1, 0, 4, 0);
    step(0,0,0,0);
    step(0,0,1,1); check("full_pushpop", 1, 2, 5, 0);
    step(0,0,0,1); check("full_drain1", 1, 4, 5, 0);
    step(0,0,0,1); check("full_drain2", 1, 6, 5, 0);
    step(0,0,0,1); check("full_drain3", 1, 8, 5, 0);
    step(0,0,0,1); check("full_drain4", 0, 0, 5, 0);
    step(0,0,1,0); check("midop_det", 1, 13, 6, 0);
    step(1,0,1,1); check("midop_reset", 0, 0, 0, 0);

    // det_in held high for three cycles.
    step(1,0,0,0);
    step(0,0,1,0);
    step(0,0,1,0);
    step(0,0,1,0);
`ifdef DET_EDGE_EN
    check("held_det", 1, 0, 1, 0);
    step(0,0,0,1); check("held_pop", 0, 0, 1, 0);
`else
    check("held_det", 1, 0, 3, 0);
    step(0,0,0,1); check("held_pop", 1, 1, 3, 0);
`endif

    // clr with a detection at the same edge and two events queued.
    step(1,0,0,0);
    step(0,0,1,0);
    step(0,0,0,0);
    step(0,0,1,0); check("clr_pre", 1, 0, 2, 0);
    step(0,1,1,0); check("clr_edge", 0, 0, 0, 0);
    step(0,0,0,0);
    step(0,0,1,0); check("clr_ts_kept", 1, 5, 1, 0);

    // Counter saturation: 300 single-cycle detections, consumer always ready.
    step(1,0,0,0);
    for (int i = 0; i < 600; i++) step(0, 0, (i % 2) == 0, 1);
    step(0,0,0,1); check("sat_count", 0, 0, 255, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/det_event_logger.md
DET_EVENT_LOGGER -- requirements
Module: det_event_logger

Interface
REQ-001 SHALL have parameter TS_W, default 16, timestamp width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, total-detection counter width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, event queue depth; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port det_in  input  1  detection strobe from the upstream sequence-detector output y.
REQ-007 SHALL have port clr  input  1  synchronous soft clear of the queue, counter and overflow flag.
REQ-008 SHALL have port ev_ready  input  1  consumer accepts the head event.
REQ-009 SHALL have port ev_valid  output  1  queue non-empty; head event presented.
REQ-010 SHALL have port ev_time  output  TS_W  timestamp of the head event.
REQ-011 SHALL have port ev_count  output  CNT_W  total detections since reset or clr.
REQ-012 SHALL have port overflow  output  1  sticky flag: an event was dropped because the queue was full.

Function
REQ-013 SHALL run a free-running timestamp counter ts, incrementing every cycle and wrapping from all-ones to 0.
REQ-014 SHALL sample det_in on each rising edge; a qualified detection pushes the current ts value (the value before increment) into the queue at that edge.
REQ-015 SHALL drive ev_valid, ev_time and ev_count from registers; a push at edge N is visible at the outputs after edge N.
REQ-016 SHALL pop the head event at a rising edge where ev_valid and ev_ready are both 1.
REQ-017 SHALL keep ev_valid and ev_time stable while ev_valid=1 and ev_ready=0.
REQ-018 SHALL deliver events in FIFO order, with wrap-around read and write pointers.
REQ-019 SHALL, on a push with the queue full and no pop at the same edge, drop the event, set overflow=1 and leave queue contents unchanged.
REQ-020 SHALL, on a push and a pop at the same edge with the queue full, accept both; occupancy stays DEPTH and overflow is unchanged.
REQ-021 SHALL, on a push and a pop at the same edge with the queue empty, not pop; the new event becomes the head.
REQ-022 SHALL increment ev_count on every qualified detection, including dropped ones, saturating at all-ones.
REQ-023 SHALL give clr priority over push and pop: the queue empties, ev_count=0, overflow=0, ts continues, and a detection at the same edge is discarded.
REQ-024 SHALL drive ev_time=0 whenever ev_valid=0.

Reset
REQ-025 SHALL, when reset=1 at a rising edge, set ts=0, empty the queue, and set ev_valid=0, ev_time=0, ev_count=0 and overflow=0.
REQ-026 SHALL give reset priority over clr, det_in and ev_ready; reset asserted mid-operation discards all queued events.
REQ-027 SHALL resume counting from ts=0 on the first edge after reset deasserts.

Configuration
REQ-028 SHALL, with macro DET_EDGE_EN defined, qualify only rising edges of det_in: det_in=1 and det_in registered from the previous cycle =0; the edge register resets to 0.
REQ-029 SHALL, without DET_EDGE_EN, qualify every cycle with det_in=1 as a detection.

Structure
REQ-030 SHALL place the default TS_W, CNT_W and DEPTH constants in shared package seq_det_pkg.
REQ-031 SHALL implement the queue as sub-module event_fifo, with push/pop/full/empty and clear ports; the logger top holds ts, edge qualification, the counter and the overflow flag.

Verification
REQ-032 SHALL verify: reset held for 2 cycles -> ev_valid=0, ev_time=0, ev_count=0, overflow=0.
REQ-033 SHALL verify: single-cycle det_in at ts=5 with ev_ready=0 -> after that edge, ev_valid=1, ev_time=5, ev_count=1.
REQ-034 SHALL verify: det_in pulses at ts=3,6,9,12,15 with ev_ready=0 and DEPTH=4 -> overflow=1 and ev_count=5; draining yields 3,6,9,12, then ev_valid=0.
REQ-035 SHALL verify: queue full with det_in and ev_ready both high at the same edge -> occupancy 4, overflow stays 0, and the new timestamp is last out.
REQ-036 SHALL verify: det_in held high for 3 cycles -> ev_count +1 with DET_EDGE_EN, +3 without.
REQ-037 SHALL verify: clr=1 with det_in=1 and 2 events queued -> next cycle ev_valid=0, ev_count=0, overflow=0, and ts not reset.
